// File: rtl/psi_seq_ctrl_if.sv
// Valid/ready element stream that carries each party's ascending array into psi_seq_ctrl.
interface psi_seq_ctrl_if #(
  parameter int unsigned W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/psi_seq_ctrl.sv
// Sequential multi-party PSI: parties stream in one at a time and a two-pointer merge shrinks an
// in-place accumulator. Define PSI_ORDER_CHECK_EN to build the sticky ordering-violation flag.
module psi_seq_ctrl #(
  parameter int unsigned W = 16,
  parameter int unsigned K = 16,
  parameter int unsigned N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  psi_seq_ctrl_if.slave          stream,
  output logic [W*K-1:0]         o,
  output logic [$clog2(K+1)-1:0] o_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int unsigned CW = $clog2(K+1);
  localparam int unsigned PW = $clog2(N+1);
  localparam logic [CW-1:0] KCnt = CW'(K);
  localparam logic [PW-1:0] LastParty = PW'(N-1);

  typedef enum logic [2:0] {StIdle, StLoad, StMerge, StNext, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q [K];
  logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]  i_q, i_d, wp_q, wp_d, rx_q, rx_d;
  logic [PW-1:0]  party_q, party_d;
  logic [W-1:0]   x_q, x_d;
  logic           x_full_q, x_full_d;
  logic           acc_we;
  logic [W-1:0]   acc_wdata;
  logic [W-1:0]   acc_i;
  logic           i_valid;
  logic           consume;
  logic           ready;

  always_comb begin
    acc_i = '0;
    for (int j = 0; j < K; j++) begin
      if (i_q == CW'(j)) acc_i = acc_q[j];
    end
  end

  assign i_valid = i_q < acc_cnt_q;

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    i_d       = i_q;
    wp_d      = wp_q;
    rx_d      = rx_q;
    party_d   = party_q;
    x_d       = x_q;
    x_full_d  = x_full_q;
    acc_we    = 1'b0;
    acc_wdata = stream.in_data;
    consume   = 1'b0;
    ready     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StLoad;
          rx_d     = '0;
          wp_d     = '0;
          i_d      = '0;
          party_d  = '0;
          x_full_d = 1'b0;
        end
      end
      StLoad: begin
        ready = 1'b1;
        if (stream.in_valid) begin
          acc_we = 1'b1;
          wp_d   = wp_q + CW'(1);
          rx_d   = rx_q + CW'(1);
          if (rx_q + CW'(1) == KCnt) state_d = StNext;
        end
      end
      StMerge: begin
        if (x_full_q) begin
          if (i_valid && acc_i < x_q) begin
            i_d = i_q + CW'(1);
          end else begin
            consume = 1'b1;
            if (i_valid && acc_i == x_q) begin
              acc_we    = 1'b1;
              acc_wdata = x_q;
              wp_d      = wp_q + CW'(1);
              i_d       = i_q + CW'(1);
            end
          end
        end
        // Gate on rx so the next party's first beat is never taken early.
        ready = (rx_q != KCnt) && (!x_full_q || consume);
        if (ready && stream.in_valid) begin
          x_d      = stream.in_data;
          x_full_d = 1'b1;
          rx_d     = rx_q + CW'(1);
        end else if (consume) begin
          x_full_d = 1'b0;
        end
        if (rx_q == KCnt && (!x_full_q || consume)) state_d = StNext;
      end
      StNext: begin
        acc_cnt_d = wp_q;
        party_d   = party_q + PW'(1);
        i_d       = '0;
        wp_d      = '0;
        rx_d      = '0;
        state_d   = (party_q == LastParty) ? StDone : StMerge;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_cnt_q <= '0;
      i_q       <= '0;
      wp_q      <= '0;
      rx_q      <= '0;
      party_q   <= '0;
      x_q       <= '0;
      x_full_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      i_q       <= i_d;
      wp_q      <= wp_d;
      rx_q      <= rx_d;
      party_q   <= party_d;
      x_q       <= x_d;
      x_full_q  <= x_full_d;
    end
  end

  // wp never passes i, so in-place writes only ever hit already-consumed entries.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      for (int j = 0; j < K; j++) begin
        if (wp_q == CW'(j)) acc_q[j] <= acc_wdata;
      end
    end
  end

`ifdef PSI_ORDER_CHECK_EN
  logic         beat;
  logic [W-1:0] last_q;
  logic         err_q;

  assign beat = stream.in_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      err_q  <= 1'b0;
    end else if (start && (state_q == StIdle || state_q == StDone)) begin
      err_q <= 1'b0;
    end else if (beat) begin
      last_q <= stream.in_data;
      if (rx_q != '0 && stream.in_data <= last_q) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    o = '0;
    for (int j = 0; j < K; j++) begin
      if (CW'(j) < acc_cnt_q) o[W*j +: W] = acc_q[j];
    end
  end

  assign o_count         = acc_cnt_q;
  assign stream.in_ready = ready;
  assign busy            = (state_q == StLoad) || (state_q == StMerge) || (state_q == StNext);
  assign done            = (state_q == StDone);
endmodule
